// File: rtl/risc8_pkg.sv
// Shared constants and types for the risc8 core front end.
package risc8_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Top opcode nibble values that fetch and decode both need to agree on.
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/risc8_sync_fifo.sv
// Registered synchronous FIFO with flush; DEPTH must be a power of two.
module risc8_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/risc8_fetch_unit.sv
// IF stage: sequential instruction fetch with a prefetch queue, branch
// redirect from EX and halt from decode.
module risc8_fetch_unit #(
    parameter int              PC_W     = risc8_pkg::PC_W,
    parameter int              INSTR_W  = risc8_pkg::INSTR_W,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = risc8_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    input  logic               id_ready,
    output logic               fetch_idle
);
    import risc8_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   out_nx;
    logic [CW:0]     inflight;
    logic            run;
    logic            redir;
    logic            accept;
    logic            keep;
    logic            pop;
    entry_t          wr_entry;
    entry_t          head;
    logic [$bits(entry_t)-1:0] fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    assign run      = (state == RUN);
    // Redirects are only honoured while fetching; once halted they are ignored.
    assign redir    = redirect_valid & run;
    // Queued plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    assign inflight = (CW+1)'(fifo_count) + (CW+1)'(outstanding);

    assign imem_req_valid = ~rst & run & ~redir & (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign out_nx = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    assign keep   = imem_rsp_valid & ~redir & (discard == '0);
    assign pop    = id_valid & id_ready;

    assign wr_entry.instr = imem_rsp_data;
    assign wr_entry.pc    = rsp_pc;
    assign head           = fifo_rdata;

    assign id_valid   = ~fifo_empty;
    assign id_instr   = fifo_empty ? '0 : head.instr;
    assign id_pc      = fifo_empty ? '0 : head.pc;
    assign fetch_idle = ~run & fifo_empty & (outstanding == '0) & (discard == '0);

    risc8_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .wdata (wr_entry),
        .pop   (pop),
        .flush (redir),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // Halt is sticky until reset.
    always_comb begin
        state_nx = state;
        if (run && halt_req) state_nx = HALTED;
    end

    // Fetch PC, response tag PC and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_nx;
            if (redir) begin
                // Every word still in flight belongs to the old path.
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                discard  <= out_nx;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_W'(1);
                if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
                if (keep) rsp_pc <= rsp_pc + PC_W'(1);
            end
        end
    end

    // A kept response with no room and no dequeue means memory broke protocol.
    assert property (@(posedge clk) disable iff (rst) !(keep && fifo_full && !pop));

endmodule

// File: tb/tb_risc8_fetch_unit.sv
// Directed bench for risc8_fetch_unit: vector table plus hand-built sequences.
module tb_risc8_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [7:0]  imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halt_req = 1'b0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_ready = 1'b1;
    logic        fetch_idle;

    // Second instance starting near the top of the address space.
    logic        req_valid2;
    logic [7:0]  req_addr2;
    logic        rsp_valid2;
    logic [15:0] rsp_data2;
    logic        id_valid2;
    logic [15:0] id_instr2;
    logic [7:0]  id_pc2;
    logic        idle2;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [7:0]  zero8 = 8'h00;

    int mem_lat = 1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    risc8_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .fetch_idle(fetch_idle)
    );

    risc8_fetch_unit #(.RESET_PC(8'hFE)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
        .imem_req_ready(one), .imem_rsp_valid(rsp_valid2),
        .imem_rsp_data(rsp_data2), .redirect_valid(zero),
        .redirect_pc(zero8), .halt_req(zero),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2),
        .id_ready(one), .fetch_idle(idle2)
    );

    function automatic logic [15:0] img(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // In-order instruction memory, 1- or 2-cycle latency.
    logic        p_v;
    logic [15:0] p_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v <= 1'b0; p_d <= '0; imem_rsp_valid <= 1'b0; imem_rsp_data <= '0;
        end else begin
            p_v <= imem_req_valid & imem_req_ready;
            p_d <= img(imem_req_addr);
            if (mem_lat == 1) begin
                imem_rsp_valid <= imem_req_valid & imem_req_ready;
                imem_rsp_data  <= img(imem_req_addr);
            end else begin
                imem_rsp_valid <= p_v;
                imem_rsp_data  <= p_d;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid2 <= 1'b0; rsp_data2 <= '0;
        end else begin
            rsp_valid2 <= req_valid2;
            rsp_data2  <= img(req_addr2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the drive point of cycle 0 after reset release.
    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; id_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rs;
        logic       rdy;
        logic       vld;
        logic [7:0] pc;
        logic       req;
        logic [7:0] addr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rs, input logic rdy, input logic vld,
                       input logic [7:0] pc, input logic req, input logic [7:0] addr);
        vec_t v;
        v.rs = rs; v.rdy = rdy; v.vld = vld; v.pc = pc; v.req = req; v.addr = addr;
        vt.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // Straight-line fetch, one instruction per cycle from cycle 2.
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01);
        add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h02);
        add(1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 8'h03);
        add(1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h04);
        add(1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 8'h05);
        add(1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h06);
        add(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h07);
        // Backpressure: decode stalled for cycles 0..9, four requests then none.
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02);
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03);
        for (int c = 4; c < 10; c++) add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h04);
        add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h04);
        add(1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 8'h04);
        add(1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h05);
        add(1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 8'h06);
        add(1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h07);
        add(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h08);
        add(1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 8'h09);
        add(1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 8'h0A);

        // Reset state.
        repeat (2) step();
        chk("rst req_valid", 32'(imem_req_valid), 0);
        chk("rst req_addr", 32'(imem_req_addr), 0);
        chk("rst id_valid", 32'(id_valid), 0);
        chk("rst id_pc", 32'(id_pc), 0);
        chk("rst fetch_idle", 32'(fetch_idle), 0);
        chk("rst addr2", 32'(req_addr2), 32'h00FE);

        // PC wrap on the RESET_PC=0xFE instance.
        rst = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = 8'(254 + k);
            @(negedge clk);
            chk($sformatf("wrap%0d id_valid", k), 32'(id_valid2), 1);
            chk($sformatf("wrap%0d id_pc", k), 32'(id_pc2), 32'(e));
            chk($sformatf("wrap%0d id_instr", k), 32'(id_instr2), 32'(img(e)));
            step();
        end

        // Vector table.
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rs) do_reset();
            id_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(vt[i].vld));
            if (vt[i].vld) begin
                chk($sformatf("vec%0d id_pc", i), 32'(id_pc), 32'(vt[i].pc));
                chk($sformatf("vec%0d id_instr", i), 32'(id_instr), 32'(img(vt[i].pc)));
            end
            chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].req));
            if (vt[i].req)
                chk($sformatf("vec%0d req_addr", i), 32'(imem_req_addr), 32'(vt[i].addr));
            step();
        end

        // Redirect to 0x0A on 2-cycle memory with pc1/pc2 in flight.
        mem_lat = 2;
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 8'h0A;
        @(negedge clk);
        chk("redir head pc", 32'(id_pc), 0);
        chk("redir req withdrawn", 32'(imem_req_valid), 0);
        step();
        redirect_valid = 1'b0;
        chk("redir new addr", 32'(imem_req_addr), 32'h0A);
        for (int c = 4; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("redir c%0d id_valid", c), 32'(id_valid), 0);
            step();
        end
        @(negedge clk);
        chk("redir first id_valid", 32'(id_valid), 1);
        chk("redir first pc", 32'(id_pc), 32'h0A);
        chk("redir first instr", 32'(id_instr), 32'(img(8'h0A)));
        step();
        @(negedge clk);
        chk("redir second pc", 32'(id_pc), 32'h0B);
        step();

        // Halt in cycle 2 with decode stalled: pc0..2 queued, then drained.
        mem_lat = 1;
        do_reset();
        id_ready = 1'b0;
        repeat (2) step();
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt c2 req_valid", 32'(imem_req_valid), 1);
        step();
        halt_req = 1'b0;
        for (int c = 3; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("halt c%0d req_valid", c), 32'(imem_req_valid), 0);
            chk($sformatf("halt c%0d id_pc", c), 32'(id_pc), 0);
            step();
        end
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("halt drain%0d pc", k), 32'(id_pc), 32'(k));
            chk($sformatf("halt drain%0d idle", k), 32'(fetch_idle), 0);
            step();
        end
        @(negedge clk);
        chk("halt empty id_valid", 32'(id_valid), 0);
        chk("halt fetch_idle", 32'(fetch_idle), 1);
        step();
        redirect_valid = 1'b1; redirect_pc = 8'h33;
        @(negedge clk);
        chk("halt redir req_valid", 32'(imem_req_valid), 0);
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("halt after%0d req_valid", c), 32'(imem_req_valid), 0);
            chk($sformatf("halt after%0d addr", c), 32'(imem_req_addr), 3);
            chk($sformatf("halt after%0d idle", c), 32'(fetch_idle), 1);
            step();
        end

        // Asynchronous reset mid-stream with the queue holding entries.
        do_reset();
        id_ready = 1'b0;
        repeat (3) step();
        #1;
        chk("mid pre id_valid", 32'(id_valid), 1);
        chk("mid pre req_valid", 32'(imem_req_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid rst id_valid", 32'(id_valid), 0);
        chk("mid rst req_valid", 32'(imem_req_valid), 0);
        chk("mid rst addr", 32'(imem_req_addr), 0);
        step();
        step();
        rst = 1'b0;
        id_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("mid restart id_valid", 32'(id_valid), 1);
        chk("mid restart pc", 32'(id_pc), 0);
        chk("mid restart instr", 32'(id_instr), 32'(img(8'h00)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
